// File: rtl/wpb_pkg.sv
// Shared types and helpers for the multi-channel WP# guard generator.
//   wp_state_t    : per-channel FSM state (IDLE / HOLD / COUNT)
//   WP_MODE_*     : per-channel trigger mode encoding on the mode input
//   hold_period() : hold length in clk cycles for a given hold_cyc setting
package wpb_pkg;

  typedef enum logic [1:0] {
    WP_IDLE  = 2'd0,
    WP_HOLD  = 2'd1,
    WP_COUNT = 2'd2
  } wp_state_t;

  localparam logic WP_MODE_LEVEL = 1'b0;
  localparam logic WP_MODE_EDGE  = 1'b1;

  // P = (hold==0 ? def : hold) * scal, evaluated at 32 bits so the product
  // never truncates for any legal hold_cyc value.
  function automatic int unsigned hold_period(input int unsigned hold,
                                              input int unsigned def,
                                              input int unsigned scal);
    return ((hold == 0) ? def : hold) * scal;
  endfunction

endpackage

// File: rtl/wpb_chan.sv
// One WP# guard channel: trigger FSM, hold counter and req edge detector.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   req        : write-pause request (level)
//   mode       : 0 = LEVEL, 1 = EDGE (sampled only while IDLE)
//   hold_cyc   : hold length in SCK periods, 0 selects WP_CYC
//   state      : current FSM state (debug / busy derivation)
//   wpb_next   : unregistered next value of this channel's wpb (1 = released)
//   done       : registered 1-clk pulse on the edge the channel returns to IDLE
// req is a plain level; there is no valid/ready handshake on this block.
module wpb_chan
  import wpb_pkg::*;
#(
  parameter int unsigned CLK_SCK_SCAL = 40,
  parameter int unsigned WP_CYC       = 16,
  parameter int unsigned MAX_WP_CYC   = 255,
  localparam int unsigned HOLD_W = $clog2(MAX_WP_CYC + 1),
  localparam int unsigned CNT_W  = (MAX_WP_CYC * CLK_SCK_SCAL > 1) ?
                                   $clog2(MAX_WP_CYC * CLK_SCK_SCAL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold_cyc,
  output wp_state_t         state,
  output logic              wpb_next,
  output logic              done
);

  wp_state_t        state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_q, arm_q;
  logic             mode_q, mode_nxt;
  logic             done_nxt;
  logic             rise;
  logic [31:0]      p_full;
  logic [CNT_W-1:0] p_m1, p_m2;

  // P is always derived from the live hold_cyc; it only matters on the
  // cycles where the counter is (re)loaded, which is what latches it.
  assign p_full = hold_period(32'(hold_cyc), WP_CYC, CLK_SCK_SCAL);
  assign p_m1   = CNT_W'(p_full - 32'd1);
  assign p_m2   = CNT_W'(p_full - 32'd2);

  // arm_q masks the first cycle after reset: a req that was already high
  // while in reset must not look like a rising edge.
  assign rise = req & ~req_q & arm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= WP_IDLE;
      cnt    <= '0;
      req_q  <= 1'b0;
      arm_q  <= 1'b0;
      mode_q <= WP_MODE_LEVEL;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      req_q  <= req;
      arm_q  <= 1'b1;
      mode_q <= mode_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    case (state)
      WP_IDLE: begin
        mode_nxt = mode;
        cnt_nxt  = '0;
        if (mode == WP_MODE_LEVEL) begin
          if (req) begin
            state_nxt = WP_HOLD;
            cnt_nxt   = p_m1;
          end
        end else if (rise) begin
          state_nxt = WP_COUNT;
          cnt_nxt   = p_m1;
        end
      end
      WP_HOLD: begin
        if (req) begin
          cnt_nxt = p_m1;
        end else if (p_full <= 32'd1) begin
          // P==1: the release falls on the very next edge; P-2 would wrap.
          state_nxt = WP_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = WP_COUNT;
          cnt_nxt   = p_m2;
        end
      end
      WP_COUNT: begin
        if (mode_q == WP_MODE_LEVEL && req) begin
          state_nxt = WP_HOLD;
          cnt_nxt   = p_m1;
        end else if (mode_q == WP_MODE_EDGE && rise) begin
          cnt_nxt = p_m1;
        end else if (cnt == '0) begin
          state_nxt = WP_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = WP_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign wpb_next = (state_nxt == WP_IDLE);

endmodule

// File: rtl/wpb_multi_gen.sv
// Multi-channel write-protect (WP#) guard generator.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   req        : per-channel write-pause request (level)
//   mode       : per-channel 0 = LEVEL, 1 = EDGE
//   hold_cyc   : per-channel hold in SCK periods, ch0 in the LSBs
//   force_wp   : global override, drives every wpb low while high
//   wpb        : registered active-low write protect per channel
//   busy       : channel FSM not IDLE
//   done       : 1-clk pulse on the edge a channel releases
module wpb_multi_gen
  import wpb_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CLK_SCK_SCAL = 40,
  parameter int unsigned WP_CYC       = 16,
  parameter int unsigned MAX_WP_CYC   = 255,
  localparam int unsigned HOLD_W = $clog2(MAX_WP_CYC + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          mode,
  input  logic [N_CH*HOLD_W-1:0]   hold_cyc,
  input  logic                     force_wp,
  output logic [N_CH-1:0]          wpb,
  output logic [N_CH-1:0]          busy,
  output logic [N_CH-1:0]          done
);

  logic [N_CH-1:0] wpb_nxt;
  wp_state_t       ch_state [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wpb_chan #(
      .CLK_SCK_SCAL (CLK_SCK_SCAL),
      .WP_CYC       (WP_CYC),
      .MAX_WP_CYC   (MAX_WP_CYC)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .req      (req[i]),
      .mode     (mode[i]),
      .hold_cyc (hold_cyc[i*HOLD_W +: HOLD_W]),
      .state    (ch_state[i]),
      .wpb_next (wpb_nxt[i]),
      .done     (done[i])
    );
    assign busy[i] = (ch_state[i] != WP_IDLE);
  end

  // force_wp is folded into the same register stage as the FSM result, so
  // it reaches the pads with the same one-edge latency as a request.
  always_ff @(posedge clk) begin
    if (reset) wpb <= '1;
    else       wpb <= wpb_nxt & ~{N_CH{force_wp}};
  end

endmodule

// File: tb/tb_wpb_multi_gen.sv
// Directed bench for wpb_multi_gen (4 channels, CLK_SCK_SCAL=4) plus a
// single-channel CLK_SCK_SCAL=1 instance for the P==1 corner.
module tb_wpb_multi_gen;

  logic        clk;
  logic        reset;
  logic [3:0]  req, mode, wpb, busy, done;
  logic [31:0] hold_cyc;
  logic        force_wp;

  logic        req1, mode1, wpb1, busy1, done1;
  logic [7:0]  hold1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wpb_multi_gen #(
    .N_CH(4), .CLK_SCK_SCAL(4), .WP_CYC(16), .MAX_WP_CYC(255)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .hold_cyc(hold_cyc),
    .force_wp(force_wp), .wpb(wpb), .busy(busy), .done(done)
  );

  wpb_multi_gen #(
    .N_CH(1), .CLK_SCK_SCAL(1), .WP_CYC(16), .MAX_WP_CYC(255)
  ) dut1 (
    .clk(clk), .reset(reset), .req(req1), .mode(mode1), .hold_cyc(hold1),
    .force_wp(1'b0), .wpb(wpb1), .busy(busy1), .done(done1)
  );

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    req      = 4'hF;
    mode     = 4'hF;
    hold_cyc = '0;
    force_wp = 1'b0;
    req1     = 1'b1;
    mode1    = 1'b1;
    hold1    = 8'd1;

    // 1: reset with req high, then release in EDGE mode
    step(3);
    check_vec("rst_wpb", wpb, 4'hF);
    check_vec("rst_busy", busy, 4'h0);
    check_vec("rst_done", done, 4'h0);
    check_vec("rst_wpb1", wpb1, 1'b1);
    reset = 1'b0;
    step(3);
    check_vec("rel_wpb", wpb, 4'hF);
    check_vec("rel_busy", busy, 4'h0);
    check_vec("rel_wpb1", wpb1, 1'b1);
    req = 4'h0; req1 = 1'b0; mode = 4'h0;
    step(2);

    // 2: LEVEL ch0, default hold (P=64), req high for 10 edges
    req[0] = 1'b1;
    step(1);
    check_vec("lvl_first", wpb, 4'hE);
    check_vec("lvl_busy", busy, 4'h1);
    step(9);
    req[0] = 1'b0;
    step(63);
    check_vec("lvl_p63_wpb", wpb, 4'hE);
    check_vec("lvl_p63_done", done, 4'h0);
    step(1);
    check_vec("lvl_p64_wpb", wpb, 4'hF);
    check_vec("lvl_p64_done", done, 4'h1);
    check_vec("lvl_p64_busy", busy, 4'h0);
    step(1);
    check_vec("lvl_done_off", done, 4'h0);

    // 3: EDGE ch1, hold_cyc=3 (P=12)
    mode[1] = 1'b1;
    hold_cyc[15:8] = 8'd3;
    req[1] = 1'b1;
    step(1);
    check_vec("edg_first", wpb, 4'hD);
    req[1] = 1'b0;
    step(11);
    check_vec("edg_p11_wpb", wpb, 4'hD);
    check_vec("edg_p11_done", done, 4'h0);
    step(1);
    check_vec("edg_p12_wpb", wpb, 4'hF);
    check_vec("edg_p12_done", done, 4'h2);
    step(1);
    check_vec("edg_done_off", done, 4'h0);
    // retrigger when cnt==5
    req[1] = 1'b1;
    step(1);
    check_vec("edg2_first", wpb, 4'hD);
    req[1] = 1'b0;
    step(6);
    req[1] = 1'b1;
    step(1);
    step(5);
    check_vec("edg2_old_end", wpb, 4'hD);
    check_vec("edg2_old_done", done, 4'h0);
    step(6);
    check_vec("edg2_p11_wpb", wpb, 4'hD);
    step(1);
    check_vec("edg2_p12_wpb", wpb, 4'hF);
    check_vec("edg2_p12_done", done, 4'h2);
    req[1] = 1'b0;
    step(1);

    // 4: LEVEL retrigger on ch2 (P=64)
    req[2] = 1'b1;
    step(1);
    check_vec("rtg_first", wpb, 4'hB);
    step(4);
    req[2] = 1'b0;
    step(20);
    check_vec("rtg_count_busy", busy, 4'h4);
    req[2] = 1'b1;
    step(1);
    check_vec("rtg_wpb", wpb, 4'hB);
    check_vec("rtg_done", done, 4'h0);
    step(2);
    req[2] = 1'b0;
    step(63);
    check_vec("rtg_p63_wpb", wpb, 4'hB);
    check_vec("rtg_p63_done", done, 4'h0);
    step(1);
    check_vec("rtg_p64_wpb", wpb, 4'hF);
    check_vec("rtg_p64_done", done, 4'h4);
    step(1);

    // 5: force_wp while idle, then a ch3 release under force
    force_wp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_vec("frc_wpb", wpb, 4'h0);
      check_vec("frc_busy", busy, 4'h0);
      check_vec("frc_done", done, 4'h0);
    end
    force_wp = 1'b0;
    step(1);
    check_vec("frc_off", wpb, 4'hF);
    mode[3] = 1'b1;
    hold_cyc[31:24] = 8'd2;
    req[3] = 1'b1;
    step(1);
    check_vec("frc3_first", wpb, 4'h7);
    req[3] = 1'b0;
    step(5);
    force_wp = 1'b1;
    step(2);
    check_vec("frc3_busy", busy, 4'h8);
    step(1);
    check_vec("frc3_done", done, 4'h8);
    check_vec("frc3_wpb", wpb, 4'h0);
    check_vec("frc3_idle", busy, 4'h0);
    step(1);
    check_vec("frc3_done_off", done, 4'h0);
    check_vec("frc3_wpb_held", wpb, 4'h0);
    force_wp = 1'b0;
    step(1);
    check_vec("frc3_release", wpb, 4'hF);

    // 6: reset mid-COUNT on ch0 with hold_cyc=255
    mode[0] = 1'b1;
    hold_cyc[7:0] = 8'd255;
    req[0] = 1'b1;
    step(1);
    check_vec("rmid_first", wpb, 4'hE);
    req[0] = 1'b0;
    step(50);
    check_vec("rmid_count", wpb, 4'hE);
    reset = 1'b1;
    step(1);
    check_vec("rmid_wpb", wpb, 4'hF);
    check_vec("rmid_busy", busy, 4'h0);
    check_vec("rmid_done", done, 4'h0);
    reset = 1'b0;
    step(3);
    check_vec("rmid_after_done", done, 4'h0);
    check_vec("rmid_after_wpb", wpb, 4'hF);

    // P==1 on the CLK_SCK_SCAL=1 instance, EDGE then LEVEL
    mode1 = 1'b1; hold1 = 8'd1;
    req1 = 1'b1;
    step(1);
    check_vec("p1e_low", wpb1, 1'b0);
    check_vec("p1e_busy", busy1, 1'b1);
    step(1);
    check_vec("p1e_high", wpb1, 1'b1);
    check_vec("p1e_done", done1, 1'b1);
    check_vec("p1e_idle", busy1, 1'b0);
    req1 = 1'b0;
    step(1);
    check_vec("p1e_done_off", done1, 1'b0);
    mode1 = 1'b0;
    step(1);
    req1 = 1'b1;
    step(1);
    check_vec("p1l_low", wpb1, 1'b0);
    req1 = 1'b0;
    step(1);
    check_vec("p1l_high", wpb1, 1'b1);
    check_vec("p1l_done", done1, 1'b1);
    step(1);
    check_vec("p1l_done_off", done1, 1'b0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
